// File: rtl/sim_test_monitor.sv
// Test harness controller: sequences core reset, runs a watchdog, and snoops serial-port
// writes for "Passed"/"Failed" verdicts. Optional serial log FIFO under `SERIAL_LOG_EN.
module sim_test_monitor #(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 5120000,
    parameter int CNT_W          = 32,
    parameter int LOG_DEPTH      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      bus_addr,
    input  logic [7:0]       bus_wdata,
    input  logic             bus_we,
    output logic             core_rst_n,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic             ser_valid,
    output logic [7:0]       ser_data,
    input  logic             log_rd,
    output logic [7:0]       log_data,
    output logic             log_empty
);

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    localparam logic [7:0]       HOLD_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [47:0]      PASS_STR     = 48'h506173736564;
    localparam logic [47:0]      FAIL_STR     = 48'h4661696C6564;

    state_t           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic [7:0]       sb_q, sb_d;
    logic [47:0]      hist_q, hist_d;
    logic             ser_valid_q, ser_valid_d;
    logic [7:0]       ser_data_q, ser_data_d;

    logic verdict_q, timeout_hit, match_pass, match_fail, capture;

    always_comb begin
        verdict_q   = pass_q | fail_q | timeout_q;
        timeout_hit = (state_q == RUN) && (cnt_q == TIMEOUT_LAST);
        match_pass  = (hist_q == PASS_STR);
        match_fail  = (hist_q == FAIL_STR);
        capture     = bus_we && (bus_addr == 16'hFF02) && bus_wdata[7];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= HOLD;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (hold_q == HOLD_LAST) state_d = RUN;
            RUN:     if (verdict_q) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = HOLD;
        endcase
    end

    // FSM outputs
    always_comb begin
        core_rst_n = (state_q != HOLD);
        running    = (state_q == RUN);
    end

    always_comb begin
        hold_d = (state_q == HOLD) ? hold_q + 8'd1 : hold_q;

        // Counter stops on the timeout clock so it holds TIMEOUT_CYCLES-1 afterwards.
        cnt_d = cnt_q;
        if (state_q == RUN && !verdict_q && !timeout_hit && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;

        // A string match on the timeout clock wins; flags are mutually exclusive.
        pass_d    = pass_q    | (!verdict_q & match_pass);
        fail_d    = fail_q    | (!verdict_q & match_fail);
        timeout_d = timeout_q | (!verdict_q & timeout_hit & !match_pass & !match_fail);

        sb_d = sb_q;
        if (bus_we && bus_addr == 16'hFF01 && state_q != DONE)
            sb_d = bus_wdata;

        ser_valid_d = capture;
        ser_data_d  = capture ? sb_q : ser_data_q;
        hist_d      = capture ? {hist_q[39:0], sb_q} : hist_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            sb_q        <= '0;
            hist_q      <= '0;
            ser_valid_q <= 1'b0;
            ser_data_q  <= '0;
        end else begin
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            sb_q        <= sb_d;
            hist_q      <= hist_d;
            ser_valid_q <= ser_valid_d;
            ser_data_q  <= ser_data_d;
        end
    end

    assign done        = verdict_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;
    assign ser_valid   = ser_valid_q;
    assign ser_data    = ser_data_q;

`ifdef SERIAL_LOG_EN
    localparam int AW = $clog2(LOG_DEPTH);

    logic [7:0]    log_mem_q [LOG_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   log_cnt_q, log_cnt_d;
    logic          push, pop;

    always_comb begin
        pop = log_rd && (log_cnt_q != '0);
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push      = ser_valid_q && ((log_cnt_q != (AW+1)'(LOG_DEPTH)) || pop);
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        log_cnt_d = log_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            log_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            log_cnt_q <= log_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) log_mem_q[wr_ptr_q] <= ser_data_q;
    end

    assign log_data  = log_mem_q[rd_ptr_q];
    assign log_empty = (log_cnt_q == '0);
`else
    localparam int LOG_DEPTH_UNUSED = LOG_DEPTH;
    logic log_rd_unused;
    assign log_rd_unused = log_rd;
    assign log_data      = 8'h00;
    assign log_empty     = 1'b1;
`endif

endmodule

// File: tb/tb_sim_test_monitor.sv
// Scoreboard bench for sim_test_monitor: serial bytes and verdicts are queued by the
// stimulus and checked by independent monitors; sequencing checks are directed.
module tb_sim_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_addr = '0;
    logic [7:0]  bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic        log_rd = 1'b0;
    logic        core_rst_n, running, done, pass, fail, timeout, ser_valid, log_empty;
    logic [31:0] cycle_count;
    logic [7:0]  ser_data, log_data;

    sim_test_monitor #(
        .RESET_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(32), .LOG_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .core_rst_n(core_rst_n), .running(running), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .cycle_count(cycle_count), .ser_valid(ser_valid),
        .ser_data(ser_data), .log_rd(log_rd), .log_data(log_data), .log_empty(log_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        p;
        logic        f;
        logic        t;
        logic [31:0] cnt;
    } verdict_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ser_q[$];
    verdict_t   verd_q[$];
    bit         done_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: serial bytes and verdicts
    always @(negedge clk) begin
        if (ser_valid) begin
            if (ser_q.size() == 0) chk("ser_unexpected", 1, 0);
            else chk("ser_data", ser_data, ser_q.pop_front());
        end
        if (!done) done_seen = 0;
        else if (!done_seen) begin
            done_seen = 1;
            if (verd_q.size() == 0) chk("verdict_unexpected", 1, 0);
            else begin
                verdict_t v;
                v = verd_q.pop_front();
                chk("verdict_pass", pass, v.p);
                chk("verdict_fail", fail, v.f);
                chk("verdict_timeout", timeout, v.t);
                chk("verdict_count", cycle_count, v.cnt);
            end
        end
    end

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(posedge clk); #1;
        bus_we = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] c, input logic [7:0] exp);
        bus_wr(16'hFF01, c);
        ser_q.push_back(exp);
        bus_wr(16'hFF02, 8'h81);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], s[i]);
    endtask

    // Holds rst for n edges, checks reset values, then checks the 4-clock HOLD
    // and the first RUN clock. Returns just after the first RUN edge.
    task automatic reset_seq(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_running", running, 0);
        chk("rst_flags", {done, pass, fail, timeout}, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_ser", {ser_valid, ser_data}, 0);
        chk("rst_log_empty", log_empty, 1);
`ifndef SERIAL_LOG_EN
        chk("rst_log_data", log_data, 0);
`endif
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("hold_core_rst_n", core_rst_n, 0);
            chk("hold_running", running, 0);
        end
        @(posedge clk); #1;
        chk("run_core_rst_n", core_rst_n, 1);
        chk("run_running", running, 1);
        chk("run_count0", cycle_count, 0);
        @(posedge clk); #1;
        chk("run_count1", cycle_count, 1);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        // Reset sequencing and pass: RUN edges E5..E18 give count 14
        verd_q.push_back('{1'b1, 1'b0, 1'b0, 32'd14});
        reset_seq(3);
        send_str("Passed");
        wait_done(5);
        repeat (2) @(posedge clk);
        #1;
        chk("done_running", running, 0);
        chk("done_core_rst_n", core_rst_n, 1);
        // SB write ignored in DONE, capture still pulses with the old shadow
        send_char("Z", "d");
        repeat (2) @(posedge clk);
        #1;
        chk("pass_count_frozen", cycle_count, 14);
        chk("pass_excl", {fail, timeout}, 0);

        // Fail without false pass match
        verd_q.push_back('{1'b0, 1'b1, 1'b0, 32'd26});
        reset_seq(2);
        send_str("PasseXFailed");
        wait_done(5);
        chk("fail_no_pass", pass, 0);

        // Timeout with non-capturing writes
        verd_q.push_back('{1'b0, 1'b0, 1'b1, 32'd99});
        reset_seq(2);
        bus_wr(16'hFF02, 8'h01);
        bus_wr(16'hFF03, 8'h81);
        wait_done(200);
        repeat (3) @(posedge clk);
        #1;
        chk("to_count_held", cycle_count, 99);
        chk("to_running", running, 0);
        chk("to_flag", timeout, 1);

        // Final capture lands so the match compare hits the timeout clock
        verd_q.push_back('{1'b1, 1'b0, 1'b0, 32'd99});
        reset_seq(2);
        send_str("Passe");
        bus_wr(16'hFF01, "d");
        for (int i = 0; i < 200 && cycle_count != 98; i++) begin
            @(posedge clk); #1;
        end
        chk("coll_count98", cycle_count, 98);
        ser_q.push_back("d");
        bus_wr(16'hFF02, 8'h81);
        wait_done(5);
        repeat (3) @(posedge clk);
        #1;
        chk("coll_no_timeout", timeout, 0);
        chk("coll_count", cycle_count, 99);

        // Reset out of DONE, then reset pulse mid-RUN
        reset_seq(2);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_running", running, 1);
        reset_seq(1);

`ifdef SERIAL_LOG_EN
        send_str("ABCDEF");
        @(posedge clk); #1;
        chk("log_not_empty", log_empty, 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = 8'h41 + 8'(i);
            chk("log_pop_data", log_data, e);
            log_rd = 1'b1;
            @(posedge clk); #1;
            log_rd = 1'b0;
        end
        chk("log_empty_after", log_empty, 1);
        log_rd = 1'b1;
        @(posedge clk); #1;
        log_rd = 1'b0;
        chk("log_pop_empty", log_empty, 1);
        send_str("G");
        @(posedge clk); #1;
        chk("log_g_pushed", log_empty, 0);
        chk("log_g_head", log_data, 8'h47);
        reset_seq(1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("ser_queue_drained", ser_q.size(), 0);
        chk("verdict_queue_drained", verd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
Synthesizable test harness controller that sits between the bench clock/reset source and dmg_main. It sequences the core reset, counts run cycles against a parametrised watchdog, and snoops CPU bus writes to the serial port (SB 0xFF01 / SC 0xFF02). It detects "Passed"/"Failed" strings emitted by test ROMs, so runs end on a verdict rather than a fixed delay. It replaces the fixed-delay reset and finish timing.

Parameters:
RESET_CYCLES, 4, clocks core_rst_n is held low after leaving reset (1..255)
TIMEOUT_CYCLES, 5120000, run clocks before timeout asserts
CNT_W, 32, width of cycle_count
LOG_DEPTH, 64, serial log FIFO entries (power of two; used only with SERIAL_LOG_EN)

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
bus_addr  in  16  CPU bus address
bus_wdata  in  8  CPU write data
bus_we  in  1  one-cycle write strobe
core_rst_n  out  1  active-low reset to dmg_main
running  out  1  high in RUN state
done  out  1  sticky; any verdict reached
pass  out  1  sticky; "Passed" matched
fail  out  1  sticky; "Failed" matched
timeout  out  1  sticky; watchdog expired
cycle_count  out  CNT_W  clocks spent in RUN, saturating
ser_valid  out  1  one-cycle pulse per captured serial byte
ser_data  out  8  captured byte, valid with ser_valid
log_rd  in  1  pop log FIFO (SERIAL_LOG_EN only)
log_data  out  8  FIFO head (SERIAL_LOG_EN only)
log_empty  out  1  FIFO empty (SERIAL_LOG_EN only)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high: state = HOLD, core_rst_n=0, running=0, and done/pass/fail/timeout=0. Also cycle_count=0, ser_valid=0, ser_data=0x00, SB shadow=0x00, history=0.
- The first clock with rst low enters HOLD with hold counter 0.
- FSM HOLD -> RUN: stays in HOLD for exactly RESET_CYCLES clocks after rst falls, with core_rst_n=0. It then moves to RUN, and core_rst_n=1 from the first RUN cycle.
- FSM RUN -> DONE: cycle_count increments by 1 each RUN clock and saturates at all-ones. When pass, fail or timeout is set, the FSM moves to DONE the next clock.
- FSM DONE: terminal. running=0, core_rst_n stays 1 and the core keeps running. cycle_count freezes. The only exit is rst.
- SB shadow: a write with bus_addr==0xFF01 loads bus_wdata into the shadow. Writes are honoured in HOLD and RUN and ignored in DONE.
- Serial capture: a write with bus_addr==0xFF02 and bus_wdata[7]==1 captures the byte. On the next clock, ser_valid=1 and ser_data=SB shadow.
- SB/SC same-cycle write: impossible on a single bus. Only the write that matches bus_addr applies.
- Serial capture in DONE: ser_valid keeps pulsing, so the post-verdict log remains visible.
- History: a 48-bit shift register; each captured byte shifts in at the low end.
- Verdict latency: the compare runs on the updated history, and the matching flag is set the cycle after the ser_valid pulse of the final byte.
- pass: history == ASCII "Passed" (0x506173736564).
- fail: history == ASCII "Failed" (0x4661696C6564).
- timeout: set when cycle_count reaches TIMEOUT_CYCLES-1 in RUN, i.e. on the TIMEOUT_CYCLES-th RUN clock.
- Priority: if a match and timeout occur on the same cycle, the match flag is set and timeout is not.
- Exclusivity: only one of pass/fail/timeout is ever set. After done, later matches and timeouts are ignored.
- Reset mid-operation: rst in any state restores all reset values on the next edge. With the log option compiled in, the FIFO also empties.

Optional Feature:
SERIAL_LOG_EN.
- Defined: every ser_valid byte is pushed into a LOG_DEPTH x 8 FIFO.
  - log_data is the head (first-word-fall-through); log_rd pops it when not empty.
  - Push when full: the byte is dropped and the FIFO is unchanged.
  - Simultaneous push and pop: both occur, and the count is unchanged.
  - Pop when empty: ignored.
- Undefined: the FIFO logic is removed, log_data=0x00 and log_empty=1 constantly, and log_rd is ignored.

Test Plan:
1. Reset sequencing: rst high 3 clocks, then low. core_rst_n is 0 for exactly 4 clocks, then 1; running=1; cycle_count reads 1 at the first RUN edge.
2. Pass detection: write "Passed" via SB=char then SC=0x81, six times. ser_valid pulses 6 times; pass=1 and done=1 one clock after the 6th pulse; fail=timeout=0; cycle_count freezes.
3. Fail and no false match: write "Passe" + "X" + "Failed". pass stays 0; fail=1 only after the final 'd'.
4. Timeout: TIMEOUT_CYCLES=100 with no serial writes. timeout=1 on RUN clock 100; done=1; cycle_count=99 held.
5. Collision and reset: the final 'd' capture lands on the timeout cycle, so pass=1 and timeout=0. Then pulse rst mid-RUN: all flags clear and HOLD re-runs for 4 clocks.
6. Log FIFO (SERIAL_LOG_EN, LOG_DEPTH=4): send 6 bytes "ABCDEF" without popping. log_empty=0; pops return 0x41,0x42,0x43,0x44; then log_empty=1.
